prog_loader: RTL and testbench

//  Write side of the picoMIPS program memory. Receives a byte stream (count byte, then instruction

---
 rtl/prog_loader.sv | 131 +++++++++++++
 tb/tb_prog_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// prog_loader: byte-stream writer for the picoMIPS program RAM; holds the CPU in reset while loading.
// Define PROG_LOADER_CHECKSUM_EN to add a trailing zero-sum checksum byte and a sticky ERROR state.
module prog_loader #(
  parameter int Psize = 5,
  parameter int Isize = 20
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             wr_en,
  output logic [Psize-1:0] wr_addr,
  output logic [Isize-1:0] wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  localparam int BPW = (Isize + 7) / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BIW-1:0] BYTE_LAST = BIW'(BPW - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;
  localparam logic [2:0] S_AFTER_DATA = S_CHECK;
`else
  localparam logic [2:0] S_AFTER_DATA = S_DONE;
`endif

  logic [2:0]       state;
  logic [Psize-1:0] count;
  logic [Psize-1:0] word_idx;
  logic [BIW-1:0]   byte_idx;
  logic [Isize-9:0] partial;
  logic [Isize-1:0] word_next;
  logic             xfer;

  // Only the low Isize-8 bits are carried between bytes, so excess bits of a word's first byte fall off.
  assign word_next = {partial, rx_data};
  assign xfer      = rx_valid & rx_ready;
  assign cpu_hold  = (state != S_IDLE);
  assign done      = (state == S_DONE);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_next;
  assign sum_next = sum + rx_data;
  assign err      = (state == S_ERROR);
  assign rx_ready = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
`else
  assign err      = 1'b0;
  assign rx_ready = (state == S_COUNT) || (state == S_DATA);
`endif

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state    <= S_IDLE;
      count    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      partial  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_COUNT;
        end
        S_COUNT: begin
          if (xfer) begin
            count    <= rx_data[Psize-1:0];
            word_idx <= '0;
            byte_idx <= '0;
            state    <= S_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum      <= rx_data;
`endif
          end
        end
        S_DATA: begin
          if (xfer) begin
            partial <= word_next[Isize-9:0];
`ifdef PROG_LOADER_CHECKSUM_EN
            sum     <= sum_next;
`endif
            if (byte_idx == BYTE_LAST) begin
              byte_idx <= '0;
              wr_en    <= 1'b1;
              wr_addr  <= word_idx;
              wr_data  <= word_next;
              word_idx <= word_idx + 1'b1;
              // count==0 wraps to all-ones here, giving the full 2**Psize words.
              if (word_idx == count - 1'b1) state <= S_AFTER_DATA;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (xfer) state <= (sum_next == 8'h00) ? S_DONE : S_ERROR;
        end
        S_ERROR: begin
          if (start) state <= S_COUNT;
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// tb_prog_loader: directed streams with a write scoreboard checked by an independent monitor.
module tb_prog_loader;
  localparam int PS = 5;
  localparam int IS = 20;

  logic          clk = 1'b0;
  logic          nReset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          wr_en;
  logic [PS-1:0] wr_addr;
  logic [IS-1:0] wr_data;
  logic          cpu_hold;
  logic          done;
  logic          err;

  prog_loader #(.Psize(PS), .Isize(IS)) dut (
    .clk(clk), .nReset(nReset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic [PS+IS-1:0] exp_q[$];
  logic [7:0] stream_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe is popped against the scoreboard; done pulses are counted.
  always @(negedge clk) begin
    if (nReset) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h:%0h required=none", wr_addr, wr_data);
        end else begin
          logic [PS+IS-1:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e[PS+IS-1:IS]));
          check("wr_data", 32'(wr_data), 32'(e[IS-1:0]));
        end
      end
      if (done) begin
        done_seen++;
        check("hold_in_done", 32'(cpu_hold), 32'd1);
        check("writes_pending_at_done", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (rx_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1 byte=%0h", b);
    end
  endtask

  task automatic push_exp(input logic [PS-1:0] a, input logic [IS-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic run_load(input bit rand_gap, input bit add_ck, input bit expect_done);
    int d0;
    logic [7:0] s;
    d0 = done_seen;
    s  = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    foreach (stream_q[i]) begin
      send(stream_q[i], rand_gap ? int'($urandom_range(0, 3)) : 0);
      s = s + stream_q[i];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (add_ck) send(8'h00 - s, 0);
`else
    if (add_ck && s == 8'hxx) $display("checksum byte not used");
`endif
    @(negedge clk);
    rx_valid = 1'b0;
    if (expect_done) begin
      for (int i = 0; i < 20 && done_seen == d0; i++) begin
        @(negedge clk);
        #1;
      end
      repeat (3) @(negedge clk);
      #1;
      check("done_pulses", 32'(done_seen - d0), 32'd1);
      check("hold_after_done", 32'(cpu_hold), 32'd0);
      check("ready_after_done", 32'(rx_ready), 32'd0);
    end else begin
      repeat (10) @(negedge clk);
      #1;
      check("no_done_on_error", 32'(done_seen - d0), 32'd0);
      check("err_sticky", 32'(err), 32'd1);
      check("hold_in_error", 32'(cpu_hold), 32'd1);
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic stream_basic();
    stream_q = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h0A, 8'hBC, 8'hDE};
    push_exp(5'd0, 20'h12345);
    push_exp(5'd1, 20'hABCDE);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({wr_en, rx_ready, cpu_hold, done, err}), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    nReset = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(rx_ready), 32'd0);

    // Basic two-word load
    stream_basic();
    run_load(1'b0, 1'b1, 1'b1);

    // Same stream with random valid gaps
    stream_basic();
    run_load(1'b1, 1'b1, 1'b1);

    // Reset after two data bytes of a word: no write, everything cleared
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(8'h02, 0);
    send(8'h01, 0);
    send(8'h23, 0);
    @(negedge clk);
    nReset = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_flags", 32'({rx_ready, cpu_hold, done, err}), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_wr_data", 32'(wr_data), 32'd0);
    nReset = 1'b1;
    stream_basic();
    run_load(1'b0, 1'b1, 1'b1);

    // Upper bits of a word's first byte are masked
    stream_q = '{8'h01, 8'hF1, 8'h23, 8'h45};
    push_exp(5'd0, 20'h12345);
    run_load(1'b0, 1'b1, 1'b1);

    // Count byte 00: full 32-word load, last write at 31
    stream_q = '{8'h00};
    for (int w = 0; w < 32; w++) begin
      logic [7:0] b0, b1, b2;
      logic [23:0] full;
      b0 = 8'(w * 21 + 3);
      b1 = 8'(w * 21 + 10);
      b2 = 8'(w * 21 + 17);
      stream_q.push_back(b0);
      stream_q.push_back(b1);
      stream_q.push_back(b2);
      full = {b0, b1, b2};
      push_exp(5'(w), full[19:0]);
    end
    run_load(1'b0, 1'b1, 1'b1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Good checksum
    stream_q = '{8'h01, 8'h00, 8'h00, 8'h05, 8'hFA};
    push_exp(5'd0, 20'h00005);
    run_load(1'b0, 1'b0, 1'b1);
    // Bad checksum: write stays, err sticks, start clears it
    stream_q = '{8'h01, 8'h00, 8'h00, 8'h05, 8'hFB};
    push_exp(5'd0, 20'h00005);
    run_load(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_cleared_by_start", 32'(err), 32'd0);
    check("count_after_error", 32'({rx_ready, cpu_hold}), 32'd3);
    nReset = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
